// File: rtl/conv3x3_proc_if.sv
`default_nettype none
// ============================================================================
// conv3x3_proc_if : frame-buffer read/write and control bundle for conv3x3_proc
// Rev 1.0
// ============================================================================
interface conv3x3_proc_if #(
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 8
);
  logic                     start;
  logic [1:0]               mode;
  logic                     busy;
  logic                     done;
  logic [c_nb_img_pxls-1:0] orig_addr;
  logic [c_nb_buf-1:0]      orig_pxl;
  logic                     proc_we;
  logic [c_nb_img_pxls-1:0] proc_addr;
  logic [c_nb_buf-1:0]      proc_pxl;

  modport master (
    output start, mode, orig_pxl,
    input  busy, done, orig_addr, proc_we, proc_addr, proc_pxl
  );

  modport slave (
    input  start, mode, orig_pxl,
    output busy, done, orig_addr, proc_we, proc_addr, proc_pxl
  );
endinterface
`default_nettype wire

// File: rtl/conv3x3_proc.sv
`default_nettype none
// ============================================================================
// conv3x3_proc : raster-stream 3x3 processor (passthrough, |gx|, |gy|, |gx|+|gy|)
// Option macro CONV3X3_THRESH_EN binarises gradient modes.    Rev 1.0
// ============================================================================
module conv3x3_proc #(
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_nb_img_pxls = 13,
  parameter int c_nb_buf      = 8,
  parameter int c_thresh      = 64
) (
  input  wire logic     clk,
  input  wire logic     rst,
  conv3x3_proc_if.slave bus
);
  localparam int c_p      = c_img_cols * c_img_rows;
  localparam int c_nb_kc  = $clog2(c_p + c_img_cols + 3);
  localparam int c_nb_k   = (c_nb_kc > c_nb_img_pxls) ? c_nb_kc : c_nb_img_pxls;
  localparam int c_nb_col = $clog2(c_img_cols);
  localparam int c_nb_row = $clog2(c_img_rows);
  localparam int c_nb_s   = c_nb_buf + 2;

  localparam logic [c_nb_k-1:0]   c_k_last_rd   = c_nb_k'(c_p - 1);
  localparam logic [c_nb_k-1:0]   c_k_last_slot = c_nb_k'(c_p + c_img_cols);
  localparam logic [c_nb_k-1:0]   c_k_end       = c_nb_k'(c_p + c_img_cols + 2);
  localparam logic [c_nb_k-1:0]   c_k_first_wr  = c_nb_k'(c_img_cols + 1);
  localparam logic [c_nb_col-1:0] c_col_last    = c_nb_col'(c_img_cols - 1);
  localparam logic [c_nb_row-1:0] c_row_last    = c_nb_row'(c_img_rows - 1);
  localparam logic [c_nb_buf-1:0] c_pxl_max     = '1;
  localparam logic [c_nb_buf-1:0] c_thr         = c_nb_buf'(c_thresh);
`ifdef CONV3X3_THRESH_EN
  localparam bit c_thresh_en = 1'b1;
`else
  localparam bit c_thresh_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              r_state, w_state_nx;
  logic [c_nb_k-1:0]   r_k, w_k_nx;
  logic                w_issue, w_rd, w_latch, w_done_nx;
  logic [1:0]          r_mode;
  logic                r_done;

  logic                r_s1_v, r_s1_rd, r_s1_wr;
  logic [c_nb_col-1:0] r_lbp;
  logic [c_nb_col-1:0] r_cc;
  logic [c_nb_row-1:0] r_cr;
  logic [c_nb_img_pxls-1:0] r_oaddr;

  logic                     r_we;
  logic [c_nb_img_pxls-1:0] r_addr;
  logic [c_nb_buf-1:0]      r_pxl;

  logic [c_nb_buf-1:0] r_lb0 [0:c_img_cols-1];
  logic [c_nb_buf-1:0] r_lb1 [0:c_img_cols-1];
  logic [c_nb_buf-1:0] r_win [0:2][0:1];
  logic [c_nb_buf-1:0] w_in;
  logic [c_nb_buf-1:0] w_col [0:2];
  logic [c_nb_buf-1:0] w_p   [0:2][0:2];

  logic signed [c_nb_buf+2:0] w_gx, w_gy;
  logic [c_nb_buf+2:0]        w_ax, w_ay;
  logic [c_nb_buf+3:0]        w_sel;
  logic [c_nb_buf-1:0]        w_sat, w_bin, w_grad, w_res;
  logic                       w_border;

  function automatic logic [c_nb_s-1:0] f_wsum(input logic [c_nb_buf-1:0] a,
                                               input logic [c_nb_buf-1:0] m,
                                               input logic [c_nb_buf-1:0] b);
    return {2'b00, a} + {1'b0, m, 1'b0} + {2'b00, b};
  endfunction

  function automatic logic [c_nb_buf+2:0] f_abs(input logic signed [c_nb_buf+2:0] v);
    return v[c_nb_buf+2] ? $unsigned(-v) : $unsigned(v);
  endfunction

  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_issue    = 1'b0;
    w_rd       = 1'b0;
    w_latch    = 1'b0;
    w_done_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nx = RUN;
          w_k_nx     = '0;
          w_latch    = 1'b1;
        end
      end
      RUN: begin
        w_issue = 1'b1;
        w_rd    = 1'b1;
        w_k_nx  = r_k + 1'b1;
        if (r_k == c_k_last_rd) w_state_nx = FLUSH;
      end
      FLUSH: begin
        // Slots past P-1 feed zeros; the extra two cycles drain the pipeline.
        w_issue = (r_k <= c_k_last_slot);
        w_k_nx  = r_k + 1'b1;
        if (r_k == c_k_end) begin
          w_state_nx = IDLE;
          w_k_nx     = r_k;
          w_done_nx  = 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_mode  <= 2'b00;
      r_done  <= 1'b0;
      r_s1_v  <= 1'b0;
      r_s1_rd <= 1'b0;
      r_s1_wr <= 1'b0;
      r_lbp   <= '0;
      r_cc    <= '0;
      r_cr    <= '0;
      r_oaddr <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_pxl   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_k     <= w_k_nx;
      r_done  <= w_done_nx;
      r_s1_v  <= w_issue;
      r_s1_rd <= w_rd;
      r_s1_wr <= w_issue && (r_k >= c_k_first_wr);
      r_we    <= r_s1_wr;
      if (r_s1_wr) begin
        r_addr <= r_oaddr;
        r_pxl  <= w_res;
      end
      if (w_latch) begin
        r_mode  <= bus.mode;
        r_lbp   <= '0;
        r_cc    <= '0;
        r_cr    <= '0;
        r_oaddr <= '0;
      end else begin
        if (r_s1_v) r_lbp <= (r_lbp == c_col_last) ? '0 : r_lbp + 1'b1;
        if (r_s1_wr) begin
          r_oaddr <= r_oaddr + 1'b1;
          if (r_cc == c_col_last) begin
            r_cc <= '0;
            r_cr <= r_cr + 1'b1;
          end else begin
            r_cc <= r_cc + 1'b1;
          end
        end
      end
    end
  end

  // Line buffers and window hold data only; contents before first overwrite never reach an output.
  always_ff @(posedge clk) begin
    if (r_s1_v) begin
      r_lb0[r_lbp] <= w_in;
      r_lb1[r_lbp] <= r_lb0[r_lbp];
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= w_col[r];
      end
    end
  end

  assign w_in     = r_s1_rd ? bus.orig_pxl : '0;
  assign w_col[0] = r_lb1[r_lbp];
  assign w_col[1] = r_lb0[r_lbp];
  assign w_col[2] = w_in;

  // The incoming column is the window's right column, so the result registers in the shift cycle.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_p[r][0] = r_win[r][0];
      w_p[r][1] = r_win[r][1];
      w_p[r][2] = w_col[r];
    end
  end

  assign w_gx = $signed({1'b0, f_wsum(w_p[0][2], w_p[1][2], w_p[2][2])})
              - $signed({1'b0, f_wsum(w_p[0][0], w_p[1][0], w_p[2][0])});
  assign w_gy = $signed({1'b0, f_wsum(w_p[2][0], w_p[2][1], w_p[2][2])})
              - $signed({1'b0, f_wsum(w_p[0][0], w_p[0][1], w_p[0][2])});
  assign w_ax = f_abs(w_gx);
  assign w_ay = f_abs(w_gy);

  always_comb begin
    w_sel = {1'b0, w_ax} + {1'b0, w_ay};
    case (r_mode)
      2'b01:   w_sel = {1'b0, w_ax};
      2'b10:   w_sel = {1'b0, w_ay};
      default: w_sel = {1'b0, w_ax} + {1'b0, w_ay};
    endcase
  end

  assign w_sat    = (w_sel > {4'b0000, c_pxl_max}) ? c_pxl_max : w_sel[c_nb_buf-1:0];
  assign w_bin    = (w_sat >= c_thr) ? c_pxl_max : '0;
  assign w_grad   = c_thresh_en ? w_bin : w_sat;
  assign w_border = (r_cr == '0) || (r_cr == c_row_last) || (r_cc == '0) || (r_cc == c_col_last);
  assign w_res    = (r_mode == 2'b00) ? w_p[1][1] : (w_border ? '0 : w_grad);

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign bus.orig_addr = (r_k > c_k_last_rd) ? c_nb_img_pxls'(c_p - 1) : r_k[c_nb_img_pxls-1:0];
  assign bus.proc_we   = r_we;
  assign bus.proc_addr = r_addr;
  assign bus.proc_pxl  = r_pxl;
endmodule
`default_nettype wire

// File: tb/tb_conv3x3_proc.sv
`default_nettype none
// tb_conv3x3_proc : scoreboard bench for conv3x3_proc (80x60x8 and 5x4x4 instances).
`timescale 1ns/1ps
module tb_conv3x3_proc;
  localparam int c_cols_a = 80, c_rows_a = 60, c_p_a = 4800;
  localparam int c_cols_b = 5,  c_rows_b = 4,  c_p_b = 20;

  typedef struct {
    int addr;
    int pxl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv3x3_proc_if #(.c_nb_img_pxls(13), .c_nb_buf(8)) bus_a ();
  conv3x3_proc_if #(.c_nb_img_pxls(5),  .c_nb_buf(4)) bus_b ();

  conv3x3_proc #(.c_img_cols(c_cols_a), .c_img_rows(c_rows_a), .c_nb_img_pxls(13),
                 .c_nb_buf(8), .c_thresh(64)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  conv3x3_proc #(.c_img_cols(c_cols_b), .c_img_rows(c_rows_b), .c_nb_img_pxls(5),
                 .c_nb_buf(4), .c_thresh(64)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;
  exp_t q_a[$], q_b[$];
  exp_t e_a, e_b;
  int   wr_a = 0, last_wr_a = 0, wr_b = 0, first_wr_b = -1;
  int   img_m [0:c_p_a-1];
  logic [7:0] mem_a [0:c_p_a-1];
  logic [3:0] mem_b [0:c_p_b-1];

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame buffer read ports: registered, one cycle latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus_a.orig_pxl <= mem_a[bus_a.orig_addr];
    bus_b.orig_pxl <= mem_b[bus_b.orig_addr];
  end

  always @(negedge clk) begin
    if (bus_a.proc_we) begin
      wr_a++;
      last_wr_a = cyc;
      if (q_a.size() == 0) check("a_extra_write", int'(bus_a.proc_addr), -1);
      else begin
        e_a = q_a.pop_front();
        check("a_addr", int'(bus_a.proc_addr), e_a.addr);
        check("a_pxl", int'(bus_a.proc_pxl), e_a.pxl);
      end
    end
    if (bus_b.proc_we) begin
      if (wr_b == 0) first_wr_b = cyc;
      wr_b++;
      if (q_b.size() == 0) check("b_extra_write", int'(bus_b.proc_addr), -1);
      else begin
        e_b = q_b.pop_front();
        check("b_addr", int'(bus_b.proc_addr), e_b.addr);
        check("b_pxl", int'(bus_b.proc_pxl), e_b.pxl);
      end
    end
  end

  function automatic int exp_pix(int cols, int rows, int nb, int mode, int n);
    int r, c, gx, gy, v, maxv;
    int p [0:2][0:2];
    r = n / cols;
    c = n % cols;
    maxv = (1 << nb) - 1;
    if (mode == 0) return img_m[n];
    if (r == 0 || r == rows - 1 || c == 0 || c == cols - 1) return 0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        p[rr][cc] = img_m[(r - 1 + rr) * cols + (c - 1 + cc)];
    gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    case (mode)
      1:       v = gx;
      2:       v = gy;
      default: v = gx + gy;
    endcase
    if (v > maxv) v = maxv;
`ifdef CONV3X3_THRESH_EN
    v = (v >= 64) ? maxv : 0;
`endif
    return v;
  endfunction

  // kind: 0 = addr low byte, 1 = vertical step at cols/2, 2 = horizontal step at rows/2, 3 = uniform
  task automatic set_img(input int kind, input int cols, input int rows, input int v);
    for (int n = 0; n < cols * rows; n++) begin
      case (kind)
        0:       img_m[n] = n & 255;
        1:       img_m[n] = ((n % cols) >= cols / 2) ? v : 0;
        2:       img_m[n] = ((n / cols) >= rows / 2) ? v : 0;
        default: img_m[n] = v;
      endcase
    end
  endtask

  task automatic load_a(input int mode);
    for (int n = 0; n < c_p_a; n++) begin
      mem_a[n] = 8'(img_m[n]);
      q_a.push_back(exp_t'{addr: n, pxl: exp_pix(c_cols_a, c_rows_a, 8, mode, n)});
    end
  endtask

  task automatic run_a(input int mode, input bit glitch);
    bit seen;
    int prev_busy;
    load_a(mode);
    wr_a = 0;
    bus_a.mode  = 2'(mode);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    if (glitch) bus_a.mode = ~bus_a.mode;
    seen = 1'b0;
    prev_busy = 1;
    for (int i = 0; i < c_p_a + 200 && !seen; i++) begin
      @(negedge clk);
      bus_a.start = (glitch && (i % 500 == 250) && (i < c_p_a)) ? 1'b1 : 1'b0;
      if (bus_a.done) begin
        seen = 1'b1;
        check("a_busy_at_done", int'(bus_a.busy), 0);
        check("a_busy_before_done", prev_busy, 1);
        check("a_done_after_last_wr", cyc - last_wr_a, 1);
        check("a_write_count", wr_a, c_p_a);
        check("a_queue_left", q_a.size(), 0);
      end
      prev_busy = int'(bus_a.busy);
    end
    if (!seen) check("a_done_timeout", 0, 1);
    bus_a.start = 1'b0;
    q_a.delete();
  endtask

  initial begin
    bit seen;
    int slot6;
    bus_a.start = 1'b0;
    bus_a.mode  = 2'b00;
    bus_b.start = 1'b0;
    bus_b.mode  = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus_a.busy), 0);
    check("rst_done", int'(bus_a.done), 0);
    check("rst_we", int'(bus_a.proc_we), 0);
    check("rst_proc_addr", int'(bus_a.proc_addr), 0);
    check("rst_proc_pxl", int'(bus_a.proc_pxl), 0);
    check("rst_orig_addr", int'(bus_a.orig_addr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    set_img(0, c_cols_a, c_rows_a, 0);
    run_a(0, 1'b0);
    set_img(1, c_cols_a, c_rows_a, 200);
    run_a(1, 1'b0);
    run_a(2, 1'b0);
    set_img(2, c_cols_a, c_rows_a, 50);
    run_a(3, 1'b0);
    set_img(1, c_cols_a, c_rows_a, 10);
    run_a(1, 1'b0);
    set_img(1, c_cols_a, c_rows_a, 20);
    run_a(1, 1'b0);

    // Reset while slot 1000 is being issued, then a clean frame with stray starts.
    set_img(0, c_cols_a, c_rows_a, 0);
    load_a(0);
    bus_a.mode  = 2'b00;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (bus_a.orig_addr == 13'd1000) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check("a_slot1000_timeout", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_we", int'(bus_a.proc_we), 0);
    check("mid_rst_busy", int'(bus_a.busy), 0);
    check("mid_rst_done", int'(bus_a.done), 0);
    q_a.delete();
    wr_a = 0;
    repeat (5) @(negedge clk);
    check("post_rst_no_writes", wr_a, 0);
    run_a(0, 1'b1);

    // Small instance: uniform 15, magnitude mode.
    set_img(3, c_cols_b, c_rows_b, 15);
    for (int n = 0; n < c_p_b; n++) begin
      mem_b[n] = 4'(img_m[n]);
      q_b.push_back(exp_t'{addr: n, pxl: exp_pix(c_cols_b, c_rows_b, 4, 3, n)});
    end
    wr_b = 0;
    first_wr_b = -1;
    slot6 = -1;
    bus_b.mode  = 2'b11;
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus_b.busy && bus_b.orig_addr == 5'd6 && slot6 < 0) slot6 = cyc;
      if (bus_b.done) begin
        seen = 1'b1;
        check("b_write_count", wr_b, c_p_b);
        check("b_first_wr_latency", first_wr_b - slot6, 2);
        check("b_busy_at_done", int'(bus_b.busy), 0);
        check("b_queue_left", q_b.size(), 0);
      end
    end
    if (!seen) check("b_done_timeout", 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
